// File: rtl/ucsbece154_mem_arbiter_if.sv
// Bus bundle between the two cache refill ports, the arbiter and the
// SDRAM-controller read port. The arbiter uses the slave view; whatever
// drives the caches and the memory side uses the master view.
`timescale 1ns/1ps
interface ucsbece154_mem_arbiter_if #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 32
);
  // I-cache side
  logic                  IReadRequest;
  logic [ADDR_WIDTH-1:0] IReadAddress;
  logic                  ICancel;
  logic [WORD_SIZE-1:0]  IDataIn;
  logic                  IDataReady;
  logic                  IDone;
  // D-cache side
  logic                  DReadRequest;
  logic [ADDR_WIDTH-1:0] DReadAddress;
  logic [WORD_SIZE-1:0]  DDataIn;
  logic                  DDataReady;
  logic                  DDone;
  // SDRAM controller side
  logic [ADDR_WIDTH-1:0] MemReadAddress;
  logic                  MemReadRequest;
  logic [WORD_SIZE-1:0]  MemDataIn;
  logic                  MemDataReady;
  // status
  logic                  Busy;

  modport slave (
    input  IReadRequest, IReadAddress, ICancel,
    output IDataIn, IDataReady, IDone,
    input  DReadRequest, DReadAddress,
    output DDataIn, DDataReady, DDone,
    output MemReadAddress, MemReadRequest,
    input  MemDataIn, MemDataReady,
    output Busy
  );

  modport master (
    output IReadRequest, IReadAddress, ICancel,
    input  IDataIn, IDataReady, IDone,
    output DReadRequest, DReadAddress,
    input  DDataIn, DDataReady, DDone,
    input  MemReadAddress, MemReadRequest,
    output MemDataIn, MemDataReady,
    input  Busy
  );
endinterface

// File: rtl/ucsbece154_mem_arbiter.sv
// Refill arbiter: shares one SDRAM read port between the I-cache and the
// D-cache. One block-aligned burst of BLOCK_WORDS beats per grant, beats
// steered to the owner, a one-cycle GAP after each burst so a requester can
// drop its level request after Done. An I-side refill can be cancelled by a
// mispredict; its remaining beats are counted but discarded.
// Optional build macro: ARB_ROUND_ROBIN_EN selects round-robin arbitration
// between simultaneous requests; when undefined, D has fixed priority over I.
`timescale 1ns/1ps
module ucsbece154_mem_arbiter #(
  parameter int BLOCK_WORDS = 4,
  parameter int WORD_SIZE   = 32,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                    Clk,
  input  logic                    Reset,
  ucsbece154_mem_arbiter_if.slave bus
);
  localparam int CNT_W  = $clog2(BLOCK_WORDS);
  localparam int OFFSET = CNT_W + 2;  // word-in-block bits plus byte-in-word bits
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;
  typedef enum logic {OWN_D = 1'b0, OWN_I = 1'b1} owner_t;

  state_t                state_reg, state_next;
  owner_t                owner_reg, owner_next;
  logic                  cancelled_reg, cancelled_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                  req_reg, req_next;

  logic                  i_elig, d_elig, grant, grant_i;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  beat, at_last, i_ready, d_ready;
  logic [WORD_SIZE-1:0]  beat_data;

  // A cancel seen in the same cycle as an I request makes it ineligible.
  assign i_elig = bus.IReadRequest & ~bus.ICancel;
  assign d_elig = bus.DReadRequest;
  assign grant  = i_elig | d_elig;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t rr_reg, rr_next;

  assign grant_i = (i_elig & d_elig) ? (rr_reg == OWN_I) : i_elig;

  // Point at the side that was not just granted (cancelled I grants included).
  always_comb begin
    rr_next = rr_reg;
    if (state_reg == IDLE && grant)
      rr_next = grant_i ? OWN_D : OWN_I;
  end

  // Round-robin pointer register.
  always_ff @(posedge Clk) begin
    if (Reset) rr_reg <= OWN_I;
    else       rr_reg <= rr_next;
  end
`else
  assign grant_i = i_elig & ~d_elig;
`endif

  assign sel_addr = grant_i ? bus.IReadAddress : bus.DReadAddress;

  // Beat steering. The live ICancel term drops a beat arriving in the very
  // cycle of the cancel, before cancelled_reg has had a chance to set.
  assign beat    = bus.MemDataReady & (state_reg == BURST);
  assign at_last = (count_reg == LAST_BEAT);
  assign i_ready = beat & (owner_reg == OWN_I) & ~cancelled_reg & ~bus.ICancel;
  assign d_ready = beat & (owner_reg == OWN_D);

  assign beat_data      = bus.MemDataIn;
  assign bus.IDataIn    = beat_data;
  assign bus.DDataIn    = beat_data;
  assign bus.IDataReady = i_ready;
  assign bus.DDataReady = d_ready;
  assign bus.IDone      = i_ready & at_last;
  assign bus.DDone      = d_ready & at_last;

  assign bus.MemReadAddress = addr_reg;
  assign bus.MemReadRequest = req_reg;
  assign bus.Busy           = (state_reg != IDLE);

  // Next-state: grant in IDLE, count beats in BURST, single dead cycle in GAP.
  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    cancelled_next = cancelled_reg;
    count_next     = count_reg;
    addr_next      = addr_reg;
    req_next       = req_reg;
    case (state_reg)
      IDLE: begin
        if (grant) begin
          owner_next     = grant_i ? OWN_I : OWN_D;
          addr_next      = {sel_addr[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
          req_next       = 1'b1;
          count_next     = '0;
          cancelled_next = 1'b0;
          state_next     = BURST;
        end
      end
      BURST: begin
        if (bus.ICancel && owner_reg == OWN_I)
          cancelled_next = 1'b1;
        if (bus.MemDataReady) begin
          // The burst cannot be aborted, so cancelled beats still count.
          count_next = count_reg + CNT_W'(1);
          if (at_last) begin
            req_next   = 1'b0;
            state_next = GAP;
          end
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and burst registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg     <= IDLE;
      owner_reg     <= OWN_D;
      cancelled_reg <= 1'b0;
      count_reg     <= '0;
      addr_reg      <= '0;
      req_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      cancelled_reg <= cancelled_next;
      count_reg     <= count_next;
      addr_reg      <= addr_next;
      req_reg       <= req_next;
    end
  end
endmodule

// File: tb/tb_ucsbece154_mem_arbiter.sv
// Scoreboard bench for the refill arbiter: stimulus pushes expected beats and
// burst addresses; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_ucsbece154_mem_arbiter;
  logic Clk;
  logic Reset;

  ucsbece154_mem_arbiter_if #(.WORD_SIZE(32), .ADDR_WIDTH(32)) bus ();

  ucsbece154_mem_arbiter #(
    .BLOCK_WORDS(4), .WORD_SIZE(32), .ADDR_WIDTH(32)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        side_i;
    logic [31:0] data;
    logic        done;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] addr_q[$];
  beat_t       e;
  logic [31:0] a;
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          mon_en   = 1'b0;
  logic        prev_req = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic beat(input bit fwd, input bit side_i, input logic [31:0] d, input bit last);
    beat_t b;
    bus.MemDataReady = 1'b1;
    bus.MemDataIn    = d;
    if (fwd) begin
      b.side_i = side_i;
      b.data   = d;
      b.done   = last;
      exp_q.push_back(b);
    end
    cyc();
    bus.MemDataReady = 1'b0;
  endtask

  task automatic full_burst(input bit side_i, input logic [31:0] base);
    for (int k = 0; k < 4; k++)
      beat(1'b1, side_i, base + 32'(k), (k == 3));
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
  endtask

  // Monitor: every cycle either a pushed beat is due, or no beat may appear.
  always @(negedge Clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.side_i) begin
          chk("i_ready", bus.IDataReady, 1);
          chk("i_data", bus.IDataIn, e.data);
          chk("i_done", bus.IDone, e.done);
          chk("d_quiet", bus.DDataReady, 0);
        end else begin
          chk("d_ready", bus.DDataReady, 1);
          chk("d_data", bus.DDataIn, e.data);
          chk("d_done", bus.DDone, e.done);
          chk("i_quiet", bus.IDataReady, 0);
        end
        $display("beat side=%s data=0x%08h done=%0d", e.side_i ? "I" : "D", e.data, e.done);
      end else begin
        chk("stray_ready", {bus.IDataReady, bus.DDataReady}, 0);
        chk("stray_done", {bus.IDone, bus.DDone}, 0);
      end
      if (bus.MemReadRequest && !prev_req) begin
        if (addr_q.size() > 0) begin
          a = addr_q.pop_front();
          chk("burst_addr", bus.MemReadAddress, a);
          $display("burst addr=0x%08h", bus.MemReadAddress);
        end else begin
          chk("unexpected_grant", bus.MemReadRequest, 0);
        end
      end
      prev_req = bus.MemReadRequest;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          first_i;
    logic [31:0] pat;
    int          nb;

    Reset = 1'b1;
    bus.IReadRequest = 1'b0; bus.IReadAddress = '0; bus.ICancel = 1'b0;
    bus.DReadRequest = 1'b0; bus.DReadAddress = '0;
    bus.MemDataIn = '0; bus.MemDataReady = 1'b0;

    // Reset state
    cyc();
    mon_en = 1'b1;
    chk("rst_req", bus.MemReadRequest, 0);
    chk("rst_addr", bus.MemReadAddress, 0);
    chk("rst_busy", bus.Busy, 0);
    cyc();
    Reset = 1'b0;
    cyc();

    // I-only refill at 0x1234
    bus.IReadRequest = 1'b1; bus.IReadAddress = 32'h0000_1234;
    addr_q.push_back(32'h0000_1230);
    cyc();
    chk("t1_req_latency", bus.MemReadRequest, 1);
    chk("t1_busy", bus.Busy, 1);
    full_burst(1'b1, 32'hA0);
    chk("t1_gap_busy", bus.Busy, 1);
    chk("t1_gap_req", bus.MemReadRequest, 0);
    bus.IReadRequest = 1'b0;
    cyc();
    chk("t1_idle_busy", bus.Busy, 0);

    // Simultaneous requests
    apply_reset();
`ifdef ARB_ROUND_ROBIN_EN
    first_i = 1'b1;
`else
    first_i = 1'b0;
`endif
    bus.IReadRequest = 1'b1; bus.IReadAddress = 32'h0000_0100;
    bus.DReadRequest = 1'b1; bus.DReadAddress = 32'h0000_2000;
    addr_q.push_back(first_i ? 32'h0000_0100 : 32'h0000_2000);
    addr_q.push_back(first_i ? 32'h0000_2000 : 32'h0000_0100);
    cyc();
    chk("t2_first_req", bus.MemReadRequest, 1);
    full_burst(first_i, 32'hB0);
    if (first_i) bus.IReadRequest = 1'b0;
    else         bus.DReadRequest = 1'b0;
    cyc();
    chk("t2_gap_no_grant", bus.MemReadRequest, 0);
    cyc();
    chk("t2_second_req", bus.MemReadRequest, 1);
    full_burst(!first_i, 32'hC0);
    bus.IReadRequest = 1'b0; bus.DReadRequest = 1'b0;
    cyc();

    // Cancel of an I refill after its 2nd beat; D waits behind it
    bus.IReadRequest = 1'b1; bus.IReadAddress = 32'h0000_0404;
    addr_q.push_back(32'h0000_0400);
    cyc();
    beat(1'b1, 1'b1, 32'h0000_00C0, 1'b0);
    beat(1'b1, 1'b1, 32'h0000_00C1, 1'b0);
    bus.ICancel = 1'b1; bus.IReadRequest = 1'b0;
    bus.DReadRequest = 1'b1; bus.DReadAddress = 32'h0000_3004;
    beat(1'b0, 1'b1, 32'h0000_00C2, 1'b0);
    bus.ICancel = 1'b0;
    beat(1'b0, 1'b1, 32'h0000_00C3, 1'b0);
    chk("t3_req_fall", bus.MemReadRequest, 0);
    addr_q.push_back(32'h0000_3000);
    cyc();
    chk("t3_idle_req", bus.MemReadRequest, 0);
    cyc();
    chk("t3_d_grant", bus.MemReadRequest, 1);

    // D burst with gapped beats 1,0,0,1,1,0,1; ICancel on a D beat is ignored
    pat = 32'b1011001;  // bit i = cycle i
    nb = 0;
    for (int i = 0; i < 7; i++) begin
      if (pat[i]) begin
        bus.ICancel = (nb == 1);
        beat(1'b1, 1'b0, 32'h0000_00D0 + 32'(nb), (nb == 3));
        bus.ICancel = 1'b0;
        nb++;
      end else begin
        bus.MemDataIn = 32'hDEAD_0000 + 32'(i);
        cyc();
      end
      if (i < 6) chk("t4_req_held", bus.MemReadRequest, 1);
    end
    chk("t4_req_fall", bus.MemReadRequest, 0);
    bus.DReadRequest = 1'b0;
    cyc();

    // Reset in the middle of a D burst
    bus.DReadRequest = 1'b1; bus.DReadAddress = 32'h0000_5000;
    addr_q.push_back(32'h0000_5000);
    cyc();
    beat(1'b1, 1'b0, 32'h0000_00E0, 1'b0);
    bus.DReadRequest = 1'b0;
    apply_reset();
    chk("t5_rst_req", bus.MemReadRequest, 0);
    chk("t5_rst_busy", bus.Busy, 0);
    bus.DReadRequest = 1'b1; bus.DReadAddress = 32'h0000_6008;
    addr_q.push_back(32'h0000_6000);
    cyc();
    full_burst(1'b0, 32'hF0);
    bus.DReadRequest = 1'b0;
    cyc();

    // MemDataReady while IDLE, then ICancel in IDLE blocks the I grant
    bus.MemDataReady = 1'b1; bus.MemDataIn = 32'h0000_0055;
    cyc();
    cyc();
    bus.MemDataReady = 1'b0;
    chk("t6_idle_busy", bus.Busy, 0);
    bus.IReadRequest = 1'b1; bus.IReadAddress = 32'h0000_7000; bus.ICancel = 1'b1;
    cyc();
    chk("t6_cancel_idle", bus.MemReadRequest, 0);
    bus.ICancel = 1'b0;
    addr_q.push_back(32'h0000_7000);
    cyc();
    chk("t6_grant", bus.MemReadRequest, 1);
    full_burst(1'b1, 32'h70);
    bus.IReadRequest = 1'b0;
    cyc();
    cyc();

    chk("beats_left", exp_q.size(), 0);
    chk("addrs_left", addr_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
